alu_operand_stage: RTL and testbench

//  Issue-side pipeline stage directly upstream of the ALU. Accepts decoded

---
 rtl/alu_operand_stage.sv | 189 ++++++++++++++++++
 tb/tb_alu_operand_stage.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_operand_stage.sv
// rtl/alu_operand_stage.sv - operand select, writeback forwarding and 2-entry skid buffer ahead of the ALU
module alu_operand_stage #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5,
    parameter bit FWD_EN     = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [REG_ADDR_W-1:0] in_rs1_idx,
    input  logic [REG_ADDR_W-1:0] in_rs2_idx,
    input  logic [DATA_W-1:0]     in_rs1_val,
    input  logic [DATA_W-1:0]     in_rs2_val,
    input  logic [DATA_W-1:0]     in_imm,
    input  logic                  in_use_imm,
    input  logic [2:0]            in_op,
    input  logic [REG_ADDR_W-1:0] in_rd,
    input  logic                  in_wr_en,
    input  logic                  fwd_valid,
    input  logic [REG_ADDR_W-1:0] fwd_rd,
    input  logic [DATA_W-1:0]     fwd_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_W-1:0]     dataX,
    output logic [DATA_W-1:0]     dataY,
    output logic [2:0]            control,
    output logic [REG_ADDR_W-1:0] out_rd,
    output logic                  out_wr_en
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t state;

    logic [REG_ADDR_W-1:0] head_rs1, head_rs2;
    logic                  head_use_imm;

    logic [DATA_W-1:0]     skid_x, skid_y;
    logic [2:0]            skid_op;
    logic [REG_ADDR_W-1:0] skid_rd, skid_rs1, skid_rs2;
    logic                  skid_wr_en, skid_use_imm;

    logic accept, pop, fwd_on;
    logic hit_in_rs1, hit_in_rs2, hit_head_rs1, hit_head_rs2, hit_skid_rs1, hit_skid_rs2;
    logic [DATA_W-1:0] cap_x, cap_y, head_x_snp, head_y_snp, skid_x_snp, skid_y_snp;
    logic load_cap, load_skid, skid_we;

    assign accept = in_valid & in_ready;
    assign pop    = out_valid & out_ready;
    assign fwd_on = FWD_EN & fwd_valid;

    // Register index 0 is hardwired zero, so it never takes a forwarded value.
    assign hit_in_rs1   = fwd_on && (fwd_rd == in_rs1_idx) && (in_rs1_idx != '0);
    assign hit_in_rs2   = fwd_on && (fwd_rd == in_rs2_idx) && (in_rs2_idx != '0);
    assign hit_head_rs1 = fwd_on && (fwd_rd == head_rs1)   && (head_rs1 != '0);
    assign hit_head_rs2 = fwd_on && (fwd_rd == head_rs2)   && (head_rs2 != '0);
    assign hit_skid_rs1 = fwd_on && (fwd_rd == skid_rs1)   && (skid_rs1 != '0);
    assign hit_skid_rs2 = fwd_on && (fwd_rd == skid_rs2)   && (skid_rs2 != '0);

    assign cap_x      = hit_in_rs1 ? fwd_data : in_rs1_val;
    assign cap_y      = in_use_imm ? in_imm : (hit_in_rs2 ? fwd_data : in_rs2_val);
    assign head_x_snp = hit_head_rs1 ? fwd_data : dataX;
    assign head_y_snp = (!head_use_imm && hit_head_rs2) ? fwd_data : dataY;
    assign skid_x_snp = hit_skid_rs1 ? fwd_data : skid_x;
    assign skid_y_snp = (!skid_use_imm && hit_skid_rs2) ? fwd_data : skid_y;

    always_comb begin
        load_cap  = 1'b0;
        load_skid = 1'b0;
        skid_we   = 1'b0;
        case (state)
            EMPTY: load_cap = accept;
            ONE: begin
                load_cap = accept && pop;
                skid_we  = accept && !pop;
            end
            TWO:     load_skid = pop;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= EMPTY;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else if (flush) begin
            state     <= EMPTY;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            case (state)
                EMPTY: begin
                    if (accept) begin
                        state     <= ONE;
                        out_valid <= 1'b1;
                    end
                end
                ONE: begin
                    if (accept && !pop) begin
                        state    <= TWO;
                        in_ready <= 1'b0;
                    end else if (pop && !accept) begin
                        state     <= EMPTY;
                        out_valid <= 1'b0;
                    end
                end
                TWO: begin
                    if (pop) begin
                        state    <= ONE;
                        in_ready <= 1'b1;
                    end
                end
                default: begin
                    state     <= EMPTY;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

    // Head and skid keep snooping the writeback bus every cycle they are not reloaded.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dataX        <= '0;
            dataY        <= '0;
            control      <= '0;
            out_rd       <= '0;
            out_wr_en    <= 1'b0;
            head_rs1     <= '0;
            head_rs2     <= '0;
            head_use_imm <= 1'b0;
        end else if (load_cap && !flush) begin
            dataX        <= cap_x;
            dataY        <= cap_y;
            control      <= in_op;
            out_rd       <= in_rd;
            out_wr_en    <= in_wr_en;
            head_rs1     <= in_rs1_idx;
            head_rs2     <= in_rs2_idx;
            head_use_imm <= in_use_imm;
        end else if (load_skid && !flush) begin
            dataX        <= skid_x_snp;
            dataY        <= skid_y_snp;
            control      <= skid_op;
            out_rd       <= skid_rd;
            out_wr_en    <= skid_wr_en;
            head_rs1     <= skid_rs1;
            head_rs2     <= skid_rs2;
            head_use_imm <= skid_use_imm;
        end else begin
            dataX <= head_x_snp;
            dataY <= head_y_snp;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            skid_x       <= '0;
            skid_y       <= '0;
            skid_op      <= '0;
            skid_rd      <= '0;
            skid_wr_en   <= 1'b0;
            skid_rs1     <= '0;
            skid_rs2     <= '0;
            skid_use_imm <= 1'b0;
        end else if (skid_we && !flush) begin
            skid_x       <= cap_x;
            skid_y       <= cap_y;
            skid_op      <= in_op;
            skid_rd      <= in_rd;
            skid_wr_en   <= in_wr_en;
            skid_rs1     <= in_rs1_idx;
            skid_rs2     <= in_rs2_idx;
            skid_use_imm <= in_use_imm;
        end else begin
            skid_x <= skid_x_snp;
            skid_y <= skid_y_snp;
        end
    end

endmodule

// File: tb/tb_alu_operand_stage.sv
// tb/tb_alu_operand_stage.sv - self-checking bench for alu_operand_stage
module tb_alu_operand_stage;

    logic        clk = 1'b0;
    logic        rst_n, flush, in_valid, in_ready;
    logic [4:0]  in_rs1_idx, in_rs2_idx, in_rd, fwd_rd, out_rd;
    logic [31:0] in_rs1_val, in_rs2_val, in_imm, fwd_data, dataX, dataY;
    logic        in_use_imm, in_wr_en, fwd_valid, out_valid, out_ready, out_wr_en;
    logic [2:0]  in_op, control;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    alu_operand_stage dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_rs1_idx(in_rs1_idx), .in_rs2_idx(in_rs2_idx), .in_rs1_val(in_rs1_val),
        .in_rs2_val(in_rs2_val), .in_imm(in_imm), .in_use_imm(in_use_imm), .in_op(in_op),
        .in_rd(in_rd), .in_wr_en(in_wr_en), .fwd_valid(fwd_valid), .fwd_rd(fwd_rd),
        .fwd_data(fwd_data), .out_valid(out_valid), .out_ready(out_ready), .dataX(dataX),
        .dataY(dataY), .control(control), .out_rd(out_rd), .out_wr_en(out_wr_en)
    );

    typedef struct packed {
        logic [31:0] x, y;
        logic [2:0]  op;
        logic [4:0]  rd;
        logic        wr_en;
        logic [4:0]  rs1, rs2;
        logic        use_imm;
    } ent_t;

    ent_t q[$];

    typedef struct packed {
        logic [4:0]  rs1_idx;
        logic [31:0] rs1_val;
        logic [4:0]  rs2_idx;
        logic [31:0] rs2_val;
        logic [31:0] imm;
        logic        use_imm;
        logic [2:0]  op;
        logic [4:0]  rd;
        logic        wr_en;
        logic        fv;
        logic [4:0]  frd;
        logic [31:0] fd;
        logic [31:0] exp_x, exp_y;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic hit(input logic [4:0] idx);
        return fwd_valid && (fwd_rd == idx) && (idx != 5'd0);
    endfunction

    task automatic check_outputs();
        chk("out_valid", out_valid, q.size() != 0);
        chk("in_ready", in_ready, q.size() < 2);
        if (q.size() != 0) begin
            chk("dataX", dataX, q[0].x);
            chk("dataY", dataY, q[0].y);
            chk("control", control, q[0].op);
            chk("out_rd", out_rd, q[0].rd);
            chk("out_wr_en", out_wr_en, q[0].wr_en);
        end
    endtask

    // Compare current outputs with the model, advance the model by one clock, then clock the DUT.
    task automatic step();
        ent_t e;
        bit   acc, pop;
        check_outputs();
        if (!rst_n || flush) begin
            q.delete();
        end else begin
            acc = in_valid && (q.size() < 2);
            pop = (q.size() != 0) && out_ready;
            foreach (q[i]) begin
                if (hit(q[i].rs1)) q[i].x = fwd_data;
                if (!q[i].use_imm && hit(q[i].rs2)) q[i].y = fwd_data;
            end
            if (pop) void'(q.pop_front());
            if (acc) begin
                e.x       = hit(in_rs1_idx) ? fwd_data : in_rs1_val;
                e.y       = in_use_imm ? in_imm : (hit(in_rs2_idx) ? fwd_data : in_rs2_val);
                e.op      = in_op;
                e.rd      = in_rd;
                e.wr_en   = in_wr_en;
                e.rs1     = in_rs1_idx;
                e.rs2     = in_rs2_idx;
                e.use_imm = in_use_imm;
                q.push_back(e);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_entry(input logic [31:0] x, input logic [4:0] rs2, input logic [31:0] y);
        in_rs1_idx = 5'd0; in_rs1_val = x;
        in_rs2_idx = rs2;  in_rs2_val = y;
        in_imm = 32'h0; in_use_imm = 1'b0;
        in_op = x[2:0]; in_rd = x[4:0]; in_wr_en = 1'b1;
    endtask

    logic [31:0] a0, b0, c0;

    initial begin
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        set_entry(32'h0, 5'd0, 32'h0);
        fwd_valid = 1'b0; fwd_rd = 5'd0; fwd_data = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_dataX", dataX, 32'h0);
        chk("rst_dataY", dataY, 32'h0);
        chk("rst_control", control, 3'd0);
        chk("rst_out_rd", out_rd, 5'd0);
        chk("rst_out_wr_en", out_wr_en, 1'b0);
        rst_n = 1'b1;

        vecs[0] = '{5'd1, 32'h11, 5'd2, 32'h5, 32'hFFFF_FFF0, 1'b1, 3'd1, 5'd10, 1'b1, 1'b0, 5'd0, 32'h0, 32'h11, 32'hFFFF_FFF0};
        vecs[1] = '{5'd3, 32'h7, 5'd2, 32'h22, 32'h0, 1'b0, 3'd2, 5'd11, 1'b0, 1'b1, 5'd3, 32'h55, 32'h55, 32'h22};
        vecs[2] = '{5'd0, 32'h7, 5'd2, 32'h22, 32'h0, 1'b0, 3'd3, 5'd12, 1'b1, 1'b1, 5'd0, 32'h55, 32'h7, 32'h22};
        vecs[3] = '{5'd5, 32'h99, 5'd6, 32'h1, 32'h0, 1'b0, 3'd4, 5'd13, 1'b1, 1'b1, 5'd6, 32'hABCD, 32'h99, 32'hABCD};
        vecs[4] = '{5'd5, 32'h99, 5'd6, 32'h1, 32'h40, 1'b1, 3'd5, 5'd14, 1'b0, 1'b1, 5'd6, 32'h1234, 32'h99, 32'h40};
        vecs[5] = '{5'd8, 32'h1, 5'd8, 32'h2, 32'h0, 1'b0, 3'd6, 5'd15, 1'b1, 1'b1, 5'd8, 32'h77, 32'h77, 32'h77};
        vecs[6] = '{5'd3, 32'h7, 5'd3, 32'h8, 32'h0, 1'b0, 3'd7, 5'd31, 1'b1, 1'b0, 5'd3, 32'h55, 32'h7, 32'h8};

        for (int i = 0; i < 7; i++) begin
            in_rs1_idx = vecs[i].rs1_idx; in_rs1_val = vecs[i].rs1_val;
            in_rs2_idx = vecs[i].rs2_idx; in_rs2_val = vecs[i].rs2_val;
            in_imm = vecs[i].imm; in_use_imm = vecs[i].use_imm;
            in_op = vecs[i].op; in_rd = vecs[i].rd; in_wr_en = vecs[i].wr_en;
            fwd_valid = vecs[i].fv; fwd_rd = vecs[i].frd; fwd_data = vecs[i].fd;
            in_valid = 1'b1; out_ready = 1'b1;
            step();
            in_valid = 1'b0; fwd_valid = 1'b0;
            chk($sformatf("vec%0d_valid", i), out_valid, 1'b1);
            chk($sformatf("vec%0d_x", i), dataX, vecs[i].exp_x);
            chk($sformatf("vec%0d_y", i), dataY, vecs[i].exp_y);
            chk($sformatf("vec%0d_op", i), control, vecs[i].op);
            chk($sformatf("vec%0d_rd", i), {out_wr_en, out_rd}, {vecs[i].wr_en, vecs[i].rd});
            step();
        end

        // Back-to-back streaming with no bubbles.
        out_ready = 1'b1; in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            set_entry(32'h100 + i, 5'd0, 32'h0);
            step();
            chk($sformatf("stream%0d_x", i), dataX, 32'h100 + i);
        end
        in_valid = 1'b0;
        step();

        // Backpressure: A and B fill the buffer, C waits upstream.
        out_ready = 1'b0; in_valid = 1'b1;
        set_entry(32'hA, 5'd0, 32'h0); step();
        set_entry(32'hB, 5'd0, 32'h0); step();
        chk("bp_in_ready", in_ready, 1'b0);
        set_entry(32'hC, 5'd0, 32'h0); step();
        chk("bp_head_held", dataX, 32'hA);
        out_ready = 1'b1;
        a0 = dataX; step();
        b0 = dataX; step();
        in_valid = 1'b0;
        c0 = dataX; step();
        chk("bp_order_a", a0, 32'hA);
        chk("bp_order_b", b0, 32'hB);
        chk("bp_order_c", c0, 32'hC);
        chk("bp_drained", out_valid, 1'b0);

        // Snoop a held entry, then flush it together with an incoming one.
        out_ready = 1'b0; in_valid = 1'b1;
        set_entry(32'h3, 5'd4, 32'h1); step();
        in_valid = 1'b0; fwd_valid = 1'b1; fwd_rd = 5'd4; fwd_data = 32'h9;
        step();
        chk("snoop_dataY", dataY, 32'h9);
        fwd_valid = 1'b0; flush = 1'b1; in_valid = 1'b1;
        set_entry(32'hD, 5'd0, 32'h0); step();
        chk("flush_out_valid", out_valid, 1'b0);
        chk("flush_in_ready", in_ready, 1'b1);
        flush = 1'b0; in_valid = 1'b0;
        step();
        chk("flush_dropped", out_valid, 1'b0);

        for (int i = 0; i < 3000; i++) begin
            rst_n      = ($urandom_range(0, 199) != 0);
            flush      = ($urandom_range(0, 31) == 0);
            in_valid   = $urandom_range(0, 2) != 0;
            out_ready  = $urandom_range(0, 2) != 0;
            in_rs1_idx = 5'($urandom_range(0, 7));
            in_rs2_idx = 5'($urandom_range(0, 7));
            in_rs1_val = $urandom;
            in_rs2_val = $urandom;
            in_imm     = $urandom;
            in_use_imm = $urandom_range(0, 1) != 0;
            in_op      = 3'($urandom_range(0, 7));
            in_rd      = 5'($urandom_range(0, 31));
            in_wr_en   = $urandom_range(0, 1) != 0;
            fwd_valid  = $urandom_range(0, 1) != 0;
            fwd_rd     = 5'($urandom_range(0, 7));
            fwd_data   = $urandom;
            step();
        end

        rst_n = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1; fwd_valid = 1'b0;
        repeat (3) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
